// File: rtl/dm_wait_mem.sv
// dm_wait_mem: byte-enable data memory with valid/ready requests, fixed wait-states and a write-trace port
module dm_wait_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int WAIT_CYCLES = 0,
  localparam int NB = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  input  logic [NB-1:0]         req_byteen,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [31:0]           req_pc,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  trace_we,
  output logic [31:0]           trace_addr,
  output logic [DATA_WIDTH-1:0] trace_wdata,
  output logic [31:0]           trace_pc
);
  localparam int LB = $clog2(NB);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [63:0] LIMIT = 64'(DEPTH_WORDS) * 64'(NB);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state;
  logic [7:0] cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [31:0] cap_addr, cap_pc, a_addr, a_pc, off;
  logic [NB-1:0] cap_be, a_be;
  logic [DATA_WIDTH-1:0] cap_wdata, a_wdata, merged;
  logic [AW-1:0] idx;
  logic in_range, commit, go_resp;
  // In IDLE the live request is used so a zero-wait access can respond right after accept
  assign a_addr = state == S_IDLE ? req_addr : cap_addr;
  assign a_be = state == S_IDLE ? req_byteen : cap_be;
  assign a_wdata = state == S_IDLE ? req_wdata : cap_wdata;
  assign a_pc = state == S_IDLE ? req_pc : cap_pc;
  assign off = a_addr - BASE_ADDR;
  assign in_range = a_addr >= BASE_ADDR && {32'd0, off} < LIMIT;
  assign idx = AW'(off >> LB);
  assign commit = in_range && |a_be;
  assign go_resp = (state == S_IDLE && req_valid && WAIT_CYCLES == 0) || (state == S_WAIT && cnt == 8'd0);
  always_comb begin
    merged = mem[idx];
    for (int i = 0; i < NB; i++) if (a_be[i]) merged[8*i +: 8] = a_wdata[8*i +: 8];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      req_ready <= 1'b1;
      cap_addr <= '0;
      cap_be <= '0;
      cap_wdata <= '0;
      cap_pc <= '0;
      resp_valid <= 1'b0;
      resp_err <= 1'b0;
      resp_rdata <= '0;
      trace_we <= 1'b0;
      trace_addr <= '0;
      trace_wdata <= '0;
      trace_pc <= '0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          cap_addr <= req_addr;
          cap_be <= req_byteen;
          cap_wdata <= req_wdata;
          cap_pc <= req_pc;
          req_ready <= 1'b0;
          cnt <= 8'(WAIT_CYCLES - 1);
          state <= WAIT_CYCLES == 0 ? S_RESP : S_WAIT;
        end
        S_WAIT: begin
          state <= cnt == 8'd0 ? S_RESP : S_WAIT;
          cnt <= cnt - 8'd1;
        end
        S_RESP: begin
          state <= S_IDLE;
          req_ready <= 1'b1;
          resp_valid <= 1'b0;
          resp_err <= 1'b0;
          resp_rdata <= '0;
          trace_we <= 1'b0;
          trace_addr <= '0;
          trace_wdata <= '0;
          trace_pc <= '0;
          if (trace_we) mem[idx] <= trace_wdata;
        end
        default: state <= S_IDLE;
      endcase
      if (go_resp) begin
        resp_valid <= 1'b1;
        resp_err <= !in_range;
        resp_rdata <= in_range ? merged : '0;
        trace_we <= commit;
        trace_addr <= commit ? a_addr & ~32'(NB - 1) : '0;
        trace_wdata <= commit ? merged : '0;
        trace_pc <= commit ? a_pc : '0;
      end
    end
  end
endmodule

// File: tb/tb_dm_wait_mem.sv
// tb_dm_wait_mem: two instances (0 and 3 wait-states) checked every cycle against a transaction-level memory model
module tb_dm_wait_mem;
  logic clk = 0, reset = 1;
  logic valid [2], rdy [2], rv [2], err [2], twe [2];
  logic [31:0] addr [2], wd [2], pc [2], rd [2], ta [2], twd [2], tpc [2];
  logic [3:0] be [2];
  int checks = 0, errors = 0, edge_n = 0;
  bit started = 0;
  bit busy [2];
  int acc_m [2], resp_cnt [2];
  logic [31:0] mdl [2][4096];
  logic [31:0] e_rd [2], e_ta [2], e_twd [2], e_tpc [2];
  logic e_err [2], e_we [2];
  int e_idx [2];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : gd
    dm_wait_mem #(.WAIT_CYCLES(g == 0 ? 0 : 3)) u (
      .clk(clk), .reset(reset), .req_valid(valid[g]), .req_ready(rdy[g]), .req_addr(addr[g]),
      .req_byteen(be[g]), .req_wdata(wd[g]), .req_pc(pc[g]), .resp_valid(rv[g]), .resp_rdata(rd[g]),
      .resp_err(err[g]), .trace_we(twe[g]), .trace_addr(ta[g]), .trace_wdata(twd[g]), .trace_pc(tpc[g]));
  end
  function automatic int wc(int g);
    return g == 0 ? 0 : 3;
  endfunction
  task automatic chk(string nm, int g, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 60) $display("FAIL %s[dut%0d] @edge %0d: got %h expected %h", nm, g, edge_n, act, exp);
    end
  endtask
  // Reference model: one outstanding transaction per instance, response due W edges after accept
  always @(posedge clk) begin
    logic [31:0] w;
    bit in;
    edge_n++;
    if (reset) begin
      started = 1;
      for (int g = 0; g < 2; g++) begin
        busy[g] = 0;
        for (int i = 0; i < 4096; i++) mdl[g][i] = 0;
      end
    end else for (int g = 0; g < 2; g++) begin
      if (busy[g] && edge_n == acc_m[g] + wc(g) + 1) begin
        if (e_we[g]) mdl[g][e_idx[g]] = e_twd[g];
        busy[g] = 0;
      end else if (!busy[g] && valid[g]) begin
        in = addr[g] < 32'h4000;
        e_idx[g] = int'(addr[g] / 4) % 4096;
        w = mdl[g][e_idx[g]];
        for (int k = 0; k < 4; k++) if (be[g][k]) w[8*k +: 8] = wd[g][8*k +: 8];
        e_err[g] = !in;
        e_rd[g] = in ? w : 0;
        e_we[g] = in && be[g] != 0;
        e_ta[g] = e_we[g] ? addr[g] & 32'hFFFF_FFFC : 0;
        e_twd[g] = e_we[g] ? w : 0;
        e_tpc[g] = e_we[g] ? pc[g] : 0;
        busy[g] = 1;
        acc_m[g] = edge_n;
      end
    end
  end
  always @(negedge clk) if (started) for (int g = 0; g < 2; g++) begin
    bit ev;
    ev = busy[g] && edge_n == acc_m[g] + wc(g);
    if (rv[g] === 1'b1) resp_cnt[g]++;
    chk("req_ready", g, 32'(rdy[g]), 32'(!busy[g]));
    chk("resp_valid", g, 32'(rv[g]), 32'(ev));
    chk("resp_err", g, 32'(err[g]), ev ? 32'(e_err[g]) : 0);
    chk("resp_rdata", g, rd[g], ev ? e_rd[g] : 0);
    chk("trace_we", g, 32'(twe[g]), ev ? 32'(e_we[g]) : 0);
    chk("trace_addr", g, ta[g], ev ? e_ta[g] : 0);
    chk("trace_wdata", g, twd[g], ev ? e_twd[g] : 0);
    chk("trace_pc", g, tpc[g], ev ? e_tpc[g] : 0);
  end
  task automatic xact(input int g, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d, input logic [31:0] p, output int acc);
    int n;
    bit r;
    n = 0;
    valid[g] = 1; addr[g] = a; be[g] = b; wd[g] = d; pc[g] = p;
    forever begin
      @(negedge clk);
      r = rdy[g] === 1'b1;
      @(posedge clk);
      #1;
      if (r) break;
      if (++n > 30) begin
        checks++; errors++;
        $display("FAIL accept_timeout[dut%0d]: no req_ready within 30 cycles", g);
        break;
      end
    end
    acc = edge_n;
    valid[g] = 0; addr[g] = $urandom; be[g] = 4'($urandom); wd[g] = $urandom; pc[g] = $urandom;
  endtask
  task automatic wait_resp(input int g, output int re);
    re = -1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (rv[g] === 1'b1) begin
        re = edge_n;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL resp_timeout[dut%0d]: no resp_valid within 30 cycles", g);
  endtask
  task automatic run_random(input int g, input int n);
    int acc;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = $urandom_range(0, 9) == 0 ? ($urandom_range(0, 1) ? 32'h4000 + 32'($urandom_range(0, 64)) : 32'hFFFF_FFF0)
                                    : 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
      xact(g, a, $urandom_range(0, 2) == 0 ? 4'h0 : 4'($urandom), $urandom, $urandom, acc);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask
  initial begin
    int a1, a2, re, rc;
    for (int g = 0; g < 2; g++) begin
      valid[g] = 0; addr[g] = 0; be[g] = 0; wd[g] = 0; pc[g] = 0; resp_cnt[g] = 0;
    end
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("reset_ready", 0, 32'(rdy[0]), 1);
    chk("reset_resp_valid", 0, 32'(rv[0]), 0);
    xact(0, 32'h0, 4'h0, 32'h0, 32'h0, a1);
    wait_resp(0, re);
    chk("rd0_rdata", 0, rd[0], 32'h0);
    chk("rd0_err", 0, 32'(err[0]), 0);
    chk("rd0_latency", 0, re - a1, 0);
    xact(0, 32'h10, 4'hF, 32'hDEADBEEF, 32'h3000, a1);
    wait_resp(0, re);
    chk("wr10_we", 0, 32'(twe[0]), 1);
    chk("wr10_addr", 0, ta[0], 32'h10);
    chk("wr10_wdata", 0, twd[0], 32'hDEADBEEF);
    chk("wr10_pc", 0, tpc[0], 32'h3000);
    xact(0, 32'h12, 4'b0100, 32'h00AA0000, 32'h3004, a1);
    wait_resp(0, re);
    chk("wr12_addr", 0, ta[0], 32'h10);
    chk("wr12_wdata", 0, twd[0], 32'hDEAABEEF);
    xact(0, 32'h10, 4'h0, 32'h0, 32'h0, a1);
    wait_resp(0, re);
    chk("rd10_rdata", 0, rd[0], 32'hDEAABEEF);
    xact(1, 32'h30, 4'hF, 32'h12345678, 32'h4000, a1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("w3_ready", 1, 32'(rdy[1]), 32'(k == 5));
      chk("w3_resp", 1, 32'(rv[1]), 32'(k == 4));
      wd[1] = $urandom; be[1] = 4'($urandom);
    end
    xact(1, 32'h30, 4'h0, 32'hFFFF_FFFF, 32'h0, a1);
    wait_resp(1, re);
    chk("w3_latency", 1, re - a1, 3);
    chk("w3_rdata", 1, rd[1], 32'h12345678);
    xact(1, 32'h34, 4'h3, 32'h0000_5555, 32'h0, a1);
    valid[1] = 1;
    xact(1, 32'h34, 4'h0, 32'h0, 32'h0, a2);
    chk("w3_throughput", 1, a2 - a1, 5);
    xact(0, 32'h4000, 4'h0, 32'h0, 32'h0, a1);
    wait_resp(0, re);
    chk("oor_err", 0, 32'(err[0]), 1);
    chk("oor_rdata", 0, rd[0], 0);
    chk("oor_rd_we", 0, 32'(twe[0]), 0);
    fork
      run_random(0, 300);
      run_random(1, 200);
    join
    xact(0, 32'h4000, 4'hF, 32'hCAFEF00D, 32'h10, a1);
    wait_resp(0, re);
    chk("oor_wr_we", 0, 32'(twe[0]), 0);
    chk("oor_wr_err", 0, 32'(err[0]), 1);
    for (int i = 0; i < 4096; i++) xact(0, 32'(i * 4), 4'h0, 32'h0, 32'h0, a1);
    xact(1, 32'h20, 4'hF, 32'h5A5A5A5A, 32'h77, a1);
    rc = resp_cnt[1];
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    repeat (6) @(negedge clk);
    chk("reset_drop_resp", 1, resp_cnt[1] - rc, 0);
    xact(1, 32'h20, 4'h0, 32'h0, 32'h0, a1);
    wait_resp(1, re);
    chk("post_reset_rd20", 1, rd[1], 0);
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
